// File: rtl/acc_wb_pkg.sv
// ============================================================================
// Module   : acc_wb_pkg
// Purpose  : Shared types, sizes and FSM encoding for the accumulator
//            write-back block. Option macro: ACC_WB_SCALE_BEAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

package acc_wb_pkg;

    localparam int WIDTH    = 16;
    localparam int PARALLEL = 3;
    localparam int TILE     = 128;   // multiple of BEAT
    localparam int BEAT     = 8;     // >= PARALLEL so one scale beat holds every lane
    localparam int ADDR_W   = 16;

    localparam int NB = TILE / BEAT;

`ifdef ACC_WB_SCALE_BEAT_EN
    localparam int TOTAL_BEATS = PARALLEL * NB + 1;
`else
    localparam int TOTAL_BEATS = PARALLEL * NB;
`endif

    localparam int CNT_W = $clog2(TOTAL_BEATS + 1);

    typedef logic [WIDTH-1:0] elem_t;
    typedef elem_t [BEAT-1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/acc_wb_beat_sel.sv
// ============================================================================
// Module   : acc_wb_beat_sel
// Purpose  : Combinational pick of beat k from the held snapshot; the scale
//            beat is present only with ACC_WB_SCALE_BEAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module acc_wb_beat_sel
    import acc_wb_pkg::*;
(
    input  logic [PARALLEL*TILE*WIDTH-1:0] i_acc,
`ifdef ACC_WB_SCALE_BEAT_EN
    input  logic [PARALLEL*WIDTH-1:0]      i_scale,
`endif
    input  logic [CNT_W-1:0]               i_k,
    output beat_t                          o_beat
);

    logic [CNT_W-1:0] w_lane;
    logic [CNT_W-1:0] w_off;
    int               w_base;

    always_comb begin
        w_lane = i_k / CNT_W'(NB);
        w_off  = i_k % CNT_W'(NB);
        w_base = 0;
        o_beat = '0;
        if (i_k < CNT_W'(PARALLEL * NB)) begin
            w_base = (int'(w_lane) * TILE + int'(w_off) * BEAT) * WIDTH;
            o_beat = i_acc[w_base +: BEAT*WIDTH];
        end
`ifdef ACC_WB_SCALE_BEAT_EN
        else begin
            // Scale words fill the low elements; the rest of the beat stays zero.
            for (int j = 0; j < PARALLEL; j++) begin
                o_beat[j] = i_scale[j*WIDTH +: WIDTH];
            end
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/acc_writeback.sv
// ============================================================================
// Module   : acc_writeback
// Purpose  : Snapshots accumulator tiles on the finished edge and drains them
//            as addressed beats over valid/ready. Option: ACC_WB_SCALE_BEAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module acc_writeback
    import acc_wb_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          finished_i,
    input  logic [PARALLEL*TILE*WIDTH-1:0] acc_i,
    input  logic [PARALLEL*WIDTH-1:0]     scale_i,
    input  logic [ADDR_W-1:0]             base_addr_i,
    output logic                          wb_valid_o,
    input  logic                          wb_ready_i,
    output logic [ADDR_W-1:0]             wb_addr_o,
    output logic [BEAT*WIDTH-1:0]         wb_data_o,
    output logic                          wb_last_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overflow_o
);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic                           r_fin_q;
    logic                           r_valid;
    logic                           r_last;
    logic                           r_ovf;
    logic [CNT_W-1:0]               r_cnt;
    logic [CNT_W-1:0]               w_cnt_inc;
    logic [ADDR_W-1:0]              r_addr;
    beat_t                          r_data;
    beat_t                          w_next_beat;
    logic                           w_trig;
    logic                           w_hs;
    logic                           w_final;
    logic                           w_load;
    logic [PARALLEL*TILE*WIDTH-1:0] r_acc;

`ifdef ACC_WB_SCALE_BEAT_EN
    logic [PARALLEL*WIDTH-1:0]      r_scale;
`else
    logic                           w_unused_scale;
    assign w_unused_scale = ^scale_i;
`endif

    assign w_trig    = finished_i & ~r_fin_q;
    assign w_hs      = r_valid & wb_ready_i;
    assign w_final   = w_hs & r_last;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_load      = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_final) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (w_trig) begin
                    w_load      = 1'b1;
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_fin_q <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fin_q <= finished_i;
            if (w_trig && (r_state == DRAIN)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Snapshot is data-only storage; it is always written before it is read.
    always_ff @(posedge clk_i) begin
        if (w_load) begin
            r_acc <= acc_i;
`ifdef ACC_WB_SCALE_BEAT_EN
            r_scale <= scale_i;
`endif
        end
    end

    acc_wb_beat_sel u_beat_sel (
        .i_acc   (r_acc),
`ifdef ACC_WB_SCALE_BEAT_EN
        .i_scale (r_scale),
`endif
        .i_k     (w_cnt_inc),
        .o_beat  (w_next_beat)
    );

    // Beat 0 comes straight from acc_i so the first beat is valid one cycle
    // after the trigger, before the snapshot register can feed the selector.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_last  <= (TOTAL_BEATS == 1);
            r_cnt   <= '0;
            r_addr  <= base_addr_i;
            r_data  <= acc_i[BEAT*WIDTH-1:0];
        end else if (w_hs) begin
            if (r_last) begin
                r_valid <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_inc;
                r_addr <= r_addr + ADDR_W'(1);
                r_data <= w_next_beat;
                r_last <= (w_cnt_inc == CNT_W'(TOTAL_BEATS - 1));
            end
        end
    end

    assign wb_valid_o = r_valid;
    assign wb_addr_o  = r_addr;
    assign wb_data_o  = r_data;
    assign wb_last_o  = r_last;
    assign busy_o     = (r_state == DRAIN);
    assign done_o     = (r_state == DONE);
    assign overflow_o = r_ovf;

endmodule

`default_nettype wire
